// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the pipeline write-back has priority, multi-cycle results
// queue in a small FIFO, and a starvation counter forces a one-cycle drain.
module wb_port_arbiter #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     PIPE_WRITE_EN,
  input  logic [4:0]               PIPE_WRITE_INDEX,
  input  logic [15:0]              PIPE_WRITE_DATA,
  input  logic                     MC_VALID,
  output logic                     MC_READY,
  input  logic [4:0]               MC_INDEX,
  input  logic [15:0]              MC_DATA,
  output logic                     PIPE_STALL,
  output logic [$clog2(DEPTH):0]   FIFO_COUNT,
  output logic                     WRITE_EN_RF,
  output logic [4:0]               WRITE_INDEX_RF,
  output logic [15:0]              WRITE_DATA_RF
);

  localparam int unsigned PtrW    = $clog2(DEPTH);
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

  localparam logic [CntW-1:0]    DepthC    = CntW'(DEPTH);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

  typedef enum logic [0:0] {StNormal, StDrain} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [PtrW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [StarveW-1:0]  starve_q, starve_d;
  logic                ready_q, ready_d;
  logic                we_q, we_d;
  logic [4:0]          idx_q, idx_d;
  logic [15:0]         data_q, data_d;
  logic [20:0]         mem_q [DEPTH];

  logic empty, push, pop, grant_pipe;
  logic [20:0] head;

  assign empty = (count_q == '0);
  assign push  = MC_VALID && ready_q;
  assign head  = mem_q[rptr_q];

  always_comb begin
    grant_pipe = 1'b0;
    pop        = 1'b0;
    // DRAIN ignores the pipe request; the FIFO cannot be empty there since only we pop.
    if (state_q == StDrain) begin
      pop = !empty;
    end else if (PIPE_WRITE_EN) begin
      grant_pipe = 1'b1;
    end else begin
      pop = !empty;
    end

    count_d = count_q + CntW'(push) - CntW'(pop);
    ready_d = (count_d < DepthC);
    wptr_d  = push ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + PtrW'(1) : rptr_q;

    starve_d = starve_q;
    if (state_q == StDrain || pop || empty) begin
      starve_d = '0;
    end else if (starve_q != StarveMax) begin
      starve_d = starve_q + StarveW'(1);
    end

    state_d = (state_q == StNormal && starve_d == StarveMax) ? StDrain : StNormal;

    we_d   = 1'b0;
    idx_d  = idx_q;
    data_d = data_q;
    if (grant_pipe) begin
      we_d   = (PIPE_WRITE_INDEX != 5'd0);
      idx_d  = PIPE_WRITE_INDEX;
      data_d = PIPE_WRITE_DATA;
    end else if (pop) begin
      we_d   = (head[20:16] != 5'd0);
      idx_d  = head[20:16];
      data_d = head[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StNormal;
      count_q  <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      starve_q <= '0;
      ready_q  <= 1'b0;
      we_q     <= 1'b0;
      idx_q    <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      starve_q <= starve_d;
      ready_q  <= ready_d;
      we_q     <= we_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= {MC_INDEX, MC_DATA};
    end
  end

  assign MC_READY       = ready_q;
  assign PIPE_STALL     = (state_q == StDrain);
  assign FIFO_COUNT     = count_q;
  assign WRITE_EN_RF    = we_q;
  assign WRITE_INDEX_RF = idx_q;
  assign WRITE_DATA_RF  = data_q;

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the in-order pipeline write-back stage and a multi-cycle execution unit (divide/multiply) whose results arrive asynchronously to the pipeline. Multi-cycle results are buffered in a small FIFO. The pipeline has priority; a starvation counter forces a one-cycle pipeline stall so that buffered results always drain. The block sits between the write-back stage and the register file and drives the register file's write inputs directly.

## Interface
- DEPTH, 2: multi-cycle result FIFO entries; power of two, at least 2.
- STARVE_LIMIT, 4: consecutive denied cycles before a forced drain; at least 1.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- PIPE_WRITE_EN  in  1  pipeline write-back request.
- PIPE_WRITE_INDEX  in  5  pipeline destination register.
- PIPE_WRITE_DATA  in  16  pipeline write data.
- MC_VALID  in  1  multi-cycle result valid.
- MC_READY  out  1  FIFO can accept; registered.
- MC_INDEX  in  5  multi-cycle destination register.
- MC_DATA  in  16  multi-cycle result data.
- PIPE_STALL  out  1  pipeline must hold its write-back request this cycle.
- FIFO_COUNT  out  log2(DEPTH)+1  current FIFO occupancy.
- WRITE_EN_RF  out  1  register-file write enable; registered.
- WRITE_INDEX_RF  out  5  register-file write index; registered.
- WRITE_DATA_RF  out  16  register-file write data; registered.

## Operation
- Push: a MC_VALID and MC_READY handshake on an edge writes {MC_INDEX, MC_DATA} to the FIFO tail.
- MC_READY is registered, with next value (next count < DEPTH). When full, it stays low even if a pop occurs in the same cycle; there is no pass-through.
- State machine has two states, NORMAL and DRAIN. Reset state is NORMAL.
- In NORMAL:
  - If PIPE_WRITE_EN is high, the pipe is granted.
  - Otherwise, if the FIFO is non-empty, the head is granted and popped.
  - Otherwise, nothing is granted.
- Starve counter, saturating at STARVE_LIMIT:
  - Increments in NORMAL when the FIFO is non-empty and the head is not granted.
  - Clears on any pop or when the FIFO is empty.
- NORMAL→DRAIN occurs on the edge at which the counter reaches STARVE_LIMIT.
- In DRAIN:
  - PIPE_STALL is high.
  - The FIFO head is granted and popped.
  - The pipe request is not committed.
  - DRAIN→NORMAL on the next edge, with the counter cleared.
- DRAIN always lasts exactly one cycle. The FIFO is guaranteed non-empty in DRAIN because only this block pops.
- PIPE_STALL is a decode of the state register (high iff DRAIN). The pipeline holds PIPE_WRITE_* stable while stalled.
- Grant commit: on the edge after a grant, WRITE_INDEX_RF and WRITE_DATA_RF take the granted entry. WRITE_EN_RF is 1 unless the granted index is 0.
- A granted index-0 entry is still consumed (popped or served) but produces no write.
- With no grant, WRITE_EN_RF is 0 and WRITE_INDEX_RF and WRITE_DATA_RF hold their previous values.
- Simultaneous push and pop when the FIFO is not full: count is unchanged and both take effect.
- Push and pop pointers wrap modulo DEPTH.
- Reset mid-operation:
  - All outputs go low.
  - FIFO contents are discarded: count 0, pointers 0.
  - Counter is 0 and state is NORMAL.
  - An in-flight MC result is lost; the owning unit must also be reset.

## Timing
- Reset values: MC_READY 0, PIPE_STALL 0, FIFO_COUNT 0, WRITE_EN_RF 0, WRITE_INDEX_RF 0, WRITE_DATA_RF 0.
- MC_READY rises on the first edge after rst_n deasserts.
- Grant to register-file write latency is 1 cycle.
- MC push to earliest RF write is 2 cycles: the push edge, the pop/grant cycle, then the commit edge.
- Worst-case wait for a FIFO head is STARVE_LIMIT denied cycles plus 1 DRAIN cycle.
- Throughput is one register-file write per cycle.
- FIFO_COUNT reflects the registered count and updates on the edge of the push or pop.

## Test plan
- Reset and idle: hold rst_n low, then release. All outputs are 0 while in reset. MC_READY is 1 one edge after release. With no requests, WRITE_EN_RF stays 0.
- Pipe only: PIPE_WRITE_EN=1, index 3, data 0xBEEF. On the next edge WRITE_EN_RF=1, WRITE_INDEX_RF=3, WRITE_DATA_RF=0xBEEF, and PIPE_STALL never rises.
- MC in an idle gap: push {7, 0x1234} with the pipe idle. WRITE_EN_RF=1 with index 7 and data 0x1234 appears 2 edges later, and FIFO_COUNT returns to 0.
- Starvation: push {9, 0x00AA}, then hold PIPE_WRITE_EN=1 continuously. Expect 4 pipe writes, then PIPE_STALL=1 for exactly 1 cycle. The next RF write is index 9, data 0x00AA. The held pipe write commits the cycle after.
- Full FIFO and simultaneous events: push 2 entries while the pipe is busy, so count is 2 and MC_READY is 0. With MC_VALID held, a pop does not accept the same cycle; MC_READY returns to 1 one edge later.
- Index 0 and mid-operation reset: a granted MC entry with index 0 pops with WRITE_EN_RF=0. Asserting rst_n low with count 2 clears count to 0 immediately and produces no further RF writes.
